// File: rtl/prbs_ber_checker.sv
// Receive-side PRBS bit-error-rate checker: sweeps candidate channel latencies against a
// local reference, locks on the best one, then counts total and errored bits for readout.
module prbs_ber_checker #(
    parameter int MAX_LAT   = 64,
    parameter int ALIGN_WIN = 32,
    parameter int NB_CNT    = 64,
    localparam int LAT_W    = $clog2(MAX_LAT)
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic              i_ref_bit,
    input  logic              i_rx_bit,
    output logic              o_locked,
    output logic [LAT_W-1:0]  o_latency,
    output logic [NB_CNT-1:0] o_bit_cnt,
    output logic [NB_CNT-1:0] o_err_cnt,
    output logic              o_sat
);

    localparam int WIN_W = (ALIGN_WIN > 1) ? $clog2(ALIGN_WIN) : 1;
    localparam int ERR_W = $clog2(ALIGN_WIN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_SWEEP  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MAX_LAT-2:0]  r_dly;
    logic [MAX_LAT-1:0]  w_taps;
    logic [LAT_W-1:0]    r_fill_cnt;
    logic [LAT_W-1:0]    r_cand;
    logic [WIN_W-1:0]    r_win;
    logic [ERR_W-1:0]    r_cur_err;
    logic [ERR_W-1:0]    r_best_err;
    logic [LAT_W-1:0]    r_best_lat;
    logic                r_locked;
    logic [LAT_W-1:0]    r_latency;
    logic [NB_CNT-1:0]   r_bit_cnt;
    logic [NB_CNT-1:0]   r_err_cnt;
    logic                r_sat;

    logic                w_mis_cand;
    logic                w_mis_lock;
    logic                w_fill_done;
    logic                w_win_close;
    logic                w_last_cand;
    logic [ERR_W-1:0]    w_tot;
    logic                w_better;
    logic [LAT_W-1:0]    w_best_lat_nxt;
    logic                w_start_sweep;
    logic                w_enter_lock;
    logic                w_count;
    logic [NB_CNT-1:0]   w_bit_inc;

    // Tap L of the reference: L=0 is the live bit, L>0 comes from the delay line.
    assign w_taps         = {r_dly, i_ref_bit};
    assign w_mis_cand     = i_rx_bit ^ w_taps[r_cand];
    assign w_mis_lock     = i_rx_bit ^ w_taps[r_latency];
    assign w_fill_done    = i_valid && (r_fill_cnt == LAT_W'(MAX_LAT - 1));
    assign w_win_close    = i_valid && (r_win == WIN_W'(ALIGN_WIN - 1));
    assign w_last_cand    = (r_cand == LAT_W'(MAX_LAT - 1));
    assign w_tot          = r_cur_err + ERR_W'(w_mis_cand);
    assign w_better       = (w_tot < r_best_err);
    assign w_best_lat_nxt = w_better ? r_cand : r_best_lat;
    assign w_start_sweep  = (r_state == S_FILL) && (w_state_nxt == S_SWEEP);
    assign w_enter_lock   = (r_state == S_SWEEP) && (w_state_nxt == S_LOCKED);
    assign w_count        = (r_state == S_LOCKED) && i_enable && i_valid && !r_sat;
    assign w_bit_inc      = r_bit_cnt + NB_CNT'(1);

    // State register.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a low enable overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_FILL;
                S_FILL: begin
                    if (w_fill_done) begin
                        w_state_nxt = S_SWEEP;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
                S_SWEEP: begin
                    if (w_win_close && w_last_cand) begin
                        w_state_nxt = S_LOCKED;
                    end else begin
                        w_state_nxt = S_SWEEP;
                    end
                end
                S_LOCKED: w_state_nxt = S_LOCKED;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Reference delay line, shifted on every strobe regardless of state.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dly <= '0;
        end else if (i_valid) begin
            r_dly <= w_taps[MAX_LAT-2:0];
        end
    end

    // Fill counter: flushes stale delay-line contents before the sweep starts.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fill_cnt <= '0;
        end else if (r_state != S_FILL) begin
            r_fill_cnt <= '0;
        end else if (i_valid) begin
            r_fill_cnt <= r_fill_cnt + LAT_W'(1);
        end
    end

    // Sweep bookkeeping: per-window error accumulation and best-candidate tracking.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cand     <= '0;
            r_win      <= '0;
            r_cur_err  <= '0;
            r_best_err <= '1;
            r_best_lat <= '0;
        end else if (w_start_sweep) begin
            r_cand     <= '0;
            r_win      <= '0;
            r_cur_err  <= '0;
            r_best_err <= '1;
            r_best_lat <= '0;
        end else if ((r_state == S_SWEEP) && i_valid) begin
            if (w_win_close) begin
                r_win     <= '0;
                r_cur_err <= '0;
                r_cand    <= r_cand + LAT_W'(1);
                if (w_better) begin
                    r_best_err <= w_tot;
                    r_best_lat <= r_cand;
                end
            end else begin
                r_win     <= r_win + WIN_W'(1);
                r_cur_err <= w_tot;
            end
        end
    end

    // Lock flag and selected latency; latency is only rewritten when lock is taken.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_locked  <= 1'b0;
            r_latency <= '0;
        end else begin
            r_locked <= (w_state_nxt == S_LOCKED);
            if (w_enter_lock) begin
                r_latency <= w_best_lat_nxt;
            end
        end
    end

    // Bit and error counters; error count never exceeds bit count, so only bits saturate.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
            r_sat     <= 1'b0;
        end else if (w_start_sweep) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
            r_sat     <= 1'b0;
        end else if (w_count) begin
            r_bit_cnt <= w_bit_inc;
            r_err_cnt <= r_err_cnt + NB_CNT'(w_mis_lock);
            r_sat     <= &w_bit_inc;
        end
    end

    assign o_locked  = r_locked;
    assign o_latency = r_latency;
    assign o_bit_cnt = r_bit_cnt;
    assign o_err_cnt = r_err_cnt;
    assign o_sat     = r_sat;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Directed bench for prbs_ber_checker: PRBS9 reference with a known delay, lock search,
// error counting, enable/reset interruptions and counter saturation on a narrow instance.
module tb_prbs_ber_checker;

    logic        clk;
    logic        i_reset, i_enable, i_valid, i_ref_bit, i_rx_bit;
    logic        o_locked, o_sat;
    logic [5:0]  o_latency;
    logic [63:0] o_bit_cnt, o_err_cnt;

    logic        rst2, en2, rx2;
    logic        o_locked2, o_sat2;
    logic [2:0]  o_latency2;
    logic [7:0]  o_bit_cnt2, o_err_cnt2;

    logic [8:0]  lfsr;
    logic [63:0] hist;
    logic        const_mode;
    int          errors;
    int          checks;

    prbs_ber_checker #(.MAX_LAT(64), .ALIGN_WIN(32), .NB_CNT(64)) dut (
        .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit), .o_locked(o_locked),
        .o_latency(o_latency), .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt), .o_sat(o_sat)
    );

    prbs_ber_checker #(.MAX_LAT(8), .ALIGN_WIN(16), .NB_CNT(8)) dut2 (
        .clk(clk), .i_reset(rst2), .i_enable(en2), .i_valid(i_valid),
        .i_ref_bit(i_ref_bit), .i_rx_bit(rx2), .o_locked(o_locked2),
        .o_latency(o_latency2), .o_bit_cnt(o_bit_cnt2), .o_err_cnt(o_err_cnt2), .o_sat(o_sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One valid strobe: main rx is the reference delayed 37, second rx delayed 5.
    task automatic strobe(input logic flip, input logic flip2);
        logic r;
        r = const_mode ? 1'b0 : lfsr[8];
        i_valid   = 1'b1;
        i_ref_bit = r;
        i_rx_bit  = const_mode ? 1'b1 : (hist[36] ^ flip);
        rx2       = hist[4] ^ flip2;
        @(posedge clk);
        #1;
        hist = {hist[62:0], r};
        lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        i_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) strobe(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        i_reset = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_ref_bit = 1'b0; i_rx_bit = 1'b0;
        rst2 = 1'b0; en2 = 1'b0; rx2 = 1'b0;
        lfsr = 9'h1FF; hist = 64'd0; const_mode = 1'b0;

        #2;
        check("rst_locked", {63'd0, o_locked}, 64'd0);
        check("rst_latency", {58'd0, o_latency}, 64'd0);
        check("rst_bit", o_bit_cnt, 64'd0);
        check("rst_err", o_err_cnt, 64'd0);
        check("rst_sat", {63'd0, o_sat}, 64'd0);

        // Test 1: lock on latency 37 after 64 + 2048 strobes, with a gap mid-sweep.
        @(negedge clk);
        i_reset = 1'b1; i_enable = 1'b1;
        idle(1);
        run(1000);
        idle(3);
        run(1111);
        check("t1_prelock", {63'd0, o_locked}, 64'd0);
        run(1);
        check("t1_locked", {63'd0, o_locked}, 64'd1);
        check("t1_latency", {58'd0, o_latency}, 64'd37);
        check("t1_bit0", o_bit_cnt, 64'd0);
        run(1000);
        check("t1_bit", o_bit_cnt, 64'd1000);
        check("t1_err", o_err_cnt, 64'd0);

        // Test 2: every 100th rx bit flipped.
        for (int i = 0; i < 1000; i++) strobe((i % 100) == 99, 1'b0);
        check("t2_bit", o_bit_cnt, 64'd2000);
        check("t2_err", o_err_cnt, 64'd10);

        // Test 4: enable drop from LOCKED holds counters, then drop mid-SWEEP and relock.
        i_enable = 1'b0;
        idle(1);
        check("t4_idle_locked", {63'd0, o_locked}, 64'd0);
        check("t4_idle_bit", o_bit_cnt, 64'd2000);
        check("t4_idle_lat", {58'd0, o_latency}, 64'd37);
        i_enable = 1'b1;
        idle(1);
        run(64);
        check("t4_clr_bit", o_bit_cnt, 64'd0);
        check("t4_clr_err", o_err_cnt, 64'd0);
        run(500);
        i_enable = 1'b0;
        idle(1);
        check("t4_sweep_drop", {63'd0, o_locked}, 64'd0);
        i_enable = 1'b1;
        idle(1);
        run(2111);
        check("t4_prelock", {63'd0, o_locked}, 64'd0);
        run(1);
        check("t4_relock", {63'd0, o_locked}, 64'd1);
        check("t4_latency", {58'd0, o_latency}, 64'd37);

        // Test 3: rx always opposite to a constant reference, every candidate ties.
        i_enable = 1'b0;
        idle(1);
        const_mode = 1'b1;
        i_enable = 1'b1;
        idle(1);
        run(2111);
        check("t3_hold_lat", {58'd0, o_latency}, 64'd37);
        run(1);
        check("t3_locked", {63'd0, o_locked}, 64'd1);
        check("t3_latency", {58'd0, o_latency}, 64'd0);
        run(500);
        check("t3_bit", o_bit_cnt, 64'd500);
        check("t3_err", o_err_cnt, 64'd500);

        // Test 5: asynchronous reset between edges while locked.
        #2;
        i_reset = 1'b0;
        #1;
        check("t5_locked", {63'd0, o_locked}, 64'd0);
        check("t5_latency", {58'd0, o_latency}, 64'd0);
        check("t5_bit", o_bit_cnt, 64'd0);
        check("t5_err", o_err_cnt, 64'd0);
        check("t5_sat", {63'd0, o_sat}, 64'd0);
        const_mode = 1'b0;
        i_reset = 1'b1;
        idle(1);
        run(2112);
        check("t5_relock", {63'd0, o_locked}, 64'd1);
        check("t5_latency2", {58'd0, o_latency}, 64'd37);

        // Test 6: 8-bit counters saturate at 255; the error after saturation is ignored.
        rst2 = 1'b1; en2 = 1'b1;
        idle(1);
        for (int i = 0; i < 136; i++) strobe(1'b0, 1'b0);
        check("t6_locked", {63'd0, o_locked2}, 64'd1);
        check("t6_latency", {61'd0, o_latency2}, 64'd5);
        for (int i = 0; i < 300; i++) begin
            strobe(1'b0, (i == 100) || (i == 270));
            if (i == 253) begin
                check("t6_bit254", {56'd0, o_bit_cnt2}, 64'd254);
                check("t6_nosat", {63'd0, o_sat2}, 64'd0);
            end
        end
        check("t6_bit", {56'd0, o_bit_cnt2}, 64'd255);
        check("t6_sat", {63'd0, o_sat2}, 64'd1);
        check("t6_err", {56'd0, o_err_cnt2}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
